// File: rtl/branch_predictor_gshare_pkg.sv
// Shared opcode, address/instruction types and counter encodings for the gshare predictor.
// Counter encodings are functions of the counter width so every module derives them the same way.
package branch_predictor_gshare_pkg;

  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;

  typedef logic [OPCODE_MSB:OPCODE_LSB] opcode_t;
  typedef logic [31:0]                  addr_t;
  typedef logic [31:0]                  inst_t;

  localparam opcode_t OPCODE_JAL = 7'b110_1111;
  localparam opcode_t OPCODE_BR  = 7'b110_0011;

  function automatic int cnt_weak_nt(input int cnt_bits);
    return (32'sd1 <<< (cnt_bits - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int cnt_sat_max(input int cnt_bits);
    return (32'sd1 <<< cnt_bits) - 32'sd1;
  endfunction

  function automatic addr_t imm_b(input inst_t inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic addr_t imm_j(input inst_t inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_sat_counter_update.sv
// Next value of an N-bit saturating counter; compares against the limits so it never wraps.
module sat_counter_update
  import branch_predictor_gshare_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] cnt_i,
  input  logic         inc_i,
  output logic [N-1:0] cnt_o
);

  localparam logic [N-1:0] CNT_MAX = N'(cnt_sat_max(N));
  localparam logic [N-1:0] CNT_MIN = N'(0);

  // Saturating step in the requested direction
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + N'(1);
      else                  cnt_o = cnt_i;
    end else begin
      if (cnt_i != CNT_MIN) cnt_o = cnt_i - N'(1);
      else                  cnt_o = cnt_i;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: flop-based PHT of saturating counters, speculative GHR
// with commit-time repair, and saturating commit statistics.
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int PHT_ENTRIES = 256,
  parameter int CNT_BITS    = 2,
  parameter int HIST_LEN    = 8,
  parameter int USE_GSHARE  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                predict_valid_from_fch,
  input  logic [31:0]         predict_pc_from_fch,
  input  logic [31:0]         predict_inst_from_fch,
  output logic                predicted_jump_sign_to_fch,
  output logic [31:0]         jump_pc_to_fch,
  output logic [HIST_LEN-1:0] ghr_snapshot_to_fch,
  input  logic                enable_sign_from_rob,
  input  logic [31:0]         pc_from_rob,
  input  logic [HIST_LEN-1:0] ghr_snapshot_from_rob,
  input  logic                hit_from_rob,
  input  logic                mispredict_from_rob,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
);

  localparam int                  IDX_W    = $clog2(PHT_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_WNT  = CNT_BITS'(cnt_weak_nt(CNT_BITS));
  localparam logic [31:0]         STAT_MAX = 32'hFFFF_FFFF;

  logic [CNT_BITS-1:0] pht_q [PHT_ENTRIES];
  logic [CNT_BITS-1:0] pht_d [PHT_ENTRIES];
  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_updates_q, stat_updates_d;
  logic [31:0]         stat_mispredicts_q, stat_mispredicts_d;

  opcode_t             pred_opcode_s;
  logic [IDX_W-1:0]    idx_pred_s, idx_upd_s;
  logic [CNT_BITS-1:0] cnt_next_s;
  logic                pred_taken_s;
  logic                repair_s;
  logic                unused_pc_bits;

  function automatic logic [IDX_W-1:0] pht_index(input addr_t pc, input logic [HIST_LEN-1:0] hist);
    if (USE_GSHARE != 0) return pc[IDX_W+1:2] ^ IDX_W'(hist);
    else                 return pc[IDX_W+1:2];
  endfunction

  // Works for HIST_LEN == 1 too: the oldest bit simply falls off the top.
  function automatic logic [HIST_LEN-1:0] ghr_shift(input logic [HIST_LEN-1:0] hist, input logic bit_in);
    logic [HIST_LEN:0] wide;
    wide = {hist, bit_in};
    return wide[HIST_LEN-1:0];
  endfunction

  assign unused_pc_bits = ^{predict_pc_from_fch[31:IDX_W+2], predict_pc_from_fch[1:0],
                            pc_from_rob[31:IDX_W+2], pc_from_rob[1:0]};

  assign idx_pred_s = pht_index(predict_pc_from_fch, ghr_q);
  assign idx_upd_s  = pht_index(pc_from_rob, ghr_snapshot_from_rob);
  assign repair_s   = enable_sign_from_rob && mispredict_from_rob;

  sat_counter_update #(.N(CNT_BITS)) u_cnt_upd (
    .cnt_i (pht_q[idx_upd_s]),
    .inc_i (hit_from_rob),
    .cnt_o (cnt_next_s)
  );

  // Combinational prediction from the fetched instruction and registered state
  always_comb begin
    pred_opcode_s = predict_inst_from_fch[OPCODE_MSB:OPCODE_LSB];
    case (pred_opcode_s)
      OPCODE_JAL: begin
        pred_taken_s   = 1'b1;
        jump_pc_to_fch = imm_j(predict_inst_from_fch);
      end
      OPCODE_BR: begin
        pred_taken_s   = pht_q[idx_pred_s][CNT_BITS-1];
        jump_pc_to_fch = imm_b(predict_inst_from_fch);
      end
      default: begin
        pred_taken_s   = 1'b0;
        jump_pc_to_fch = imm_b(predict_inst_from_fch);
      end
    endcase
  end

  // Next-state for history (repair wins over speculation), PHT and statistics
  always_comb begin
    ghr_d = ghr_q;
    if (repair_s)                                                  ghr_d = ghr_shift(ghr_snapshot_from_rob, hit_from_rob);
    else if (predict_valid_from_fch && pred_opcode_s == OPCODE_BR) ghr_d = ghr_shift(ghr_q, pred_taken_s);
    else                                                           ghr_d = ghr_q;

    pht_d = pht_q;
    if (enable_sign_from_rob) pht_d[idx_upd_s] = cnt_next_s;
    else                      pht_d = pht_q;

    stat_updates_d = stat_updates_q;
    if (enable_sign_from_rob && stat_updates_q != STAT_MAX) stat_updates_d = stat_updates_q + 32'd1;
    else                                                    stat_updates_d = stat_updates_q;

    stat_mispredicts_d = stat_mispredicts_q;
    if (repair_s && stat_mispredicts_q != STAT_MAX) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    else                                            stat_mispredicts_d = stat_mispredicts_q;
  end

  // State registers; every PHT entry is individually reset so the table stays in flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CNT_WNT;
      ghr_q              <= '0;
      stat_updates_q     <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      pht_q              <= pht_d;
      ghr_q              <= ghr_d;
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign predicted_jump_sign_to_fch = pred_taken_s;
  assign ghr_snapshot_to_fch        = ghr_q;
  assign stat_updates               = stat_updates_q;
  assign stat_mispredicts           = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: a gshare instance and a bimodal instance driven by one linear sequence.
module tb_branch_predictor_gshare;

  localparam logic [31:0] BR_P16  = 32'h0000_0863;  // B-imm +16
  localparam logic [31:0] BR_M4   = 32'hFE00_0EE3;  // B-imm -4
  localparam logic [31:0] JAL_P2K = 32'h0010_006F;  // J-imm +2048
  localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;  // J-imm -8
  localparam logic [31:0] ADDI    = 32'h0000_0013;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic        rst_n;
  logic        pv, en, hit, mis, taken;
  logic [31:0] ppc, pinst, rpc, jpc, su, sm;
  logic [7:0]  rsnap, snap;

  logic        b_pv, b_en, b_hit, b_mis, b_taken;
  logic [31:0] b_ppc, b_pinst, b_rpc, b_jpc, b_su, b_sm;
  logic [7:0]  b_rsnap, b_snap;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_predictor_gshare dut (
    .clk(clk), .rst_n(rst_n),
    .predict_valid_from_fch(pv), .predict_pc_from_fch(ppc), .predict_inst_from_fch(pinst),
    .predicted_jump_sign_to_fch(taken), .jump_pc_to_fch(jpc), .ghr_snapshot_to_fch(snap),
    .enable_sign_from_rob(en), .pc_from_rob(rpc), .ghr_snapshot_from_rob(rsnap),
    .hit_from_rob(hit), .mispredict_from_rob(mis),
    .stat_updates(su), .stat_mispredicts(sm)
  );

  branch_predictor_gshare #(.USE_GSHARE(0)) dut_bm (
    .clk(clk), .rst_n(rst_n),
    .predict_valid_from_fch(b_pv), .predict_pc_from_fch(b_ppc), .predict_inst_from_fch(b_pinst),
    .predicted_jump_sign_to_fch(b_taken), .jump_pc_to_fch(b_jpc), .ghr_snapshot_to_fch(b_snap),
    .enable_sign_from_rob(b_en), .pc_from_rob(b_rpc), .ghr_snapshot_from_rob(b_rsnap),
    .hit_from_rob(b_hit), .mispredict_from_rob(b_mis),
    .stat_updates(b_su), .stat_mispredicts(b_sm)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    pv = v; ppc = pc; pinst = inst;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [7:0] s, input logic h, input logic m);
    en = 1'b1; rpc = pc; rsnap = s; hit = h; mis = m;
    tick();
    en = 1'b0; mis = 1'b0;
  endtask

  task automatic b_upd(input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      b_en = 1'b1; b_rpc = 32'h100; b_rsnap = 8'h55; b_hit = h;
      tick();
      b_en = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pv = 1'b0; ppc = 32'h0; pinst = ADDI; en = 1'b0; rpc = 32'h0; rsnap = 8'h0; hit = 1'b0; mis = 1'b0;
    b_pv = 1'b0; b_ppc = 32'h100; b_pinst = BR_P16; b_en = 1'b0; b_rpc = 32'h0; b_rsnap = 8'h0;
    b_hit = 1'b0; b_mis = 1'b0;
    #2;

    // Outputs while held in reset
    fetch(1'b0, 32'h100, BR_P16);
    check("rst_br_taken", {31'd0, taken}, 32'd0);
    check("rst_snap", {24'd0, snap}, 32'd0);
    check("rst_stat_upd", su, 32'd0);
    check("rst_stat_mis", sm, 32'd0);
    fetch(1'b0, 32'h100, JAL_P2K);
    check("rst_jal_taken", {31'd0, taken}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Immediates and opcode classes
    fetch(1'b0, 32'h100, BR_P16);
    check("br_taken", {31'd0, taken}, 32'd0);
    check("br_imm_p16", jpc, 32'h0000_0010);
    check("br_snap", {24'd0, snap}, 32'd0);
    fetch(1'b0, 32'h100, BR_M4);
    check("br_imm_m4", jpc, 32'hFFFF_FFFC);
    fetch(1'b0, 32'h100, JAL_P2K);
    check("jal_taken", {31'd0, taken}, 32'd1);
    check("jal_imm_p2k", jpc, 32'h0000_0800);
    fetch(1'b0, 32'h0, JAL_M8);
    check("jal_imm_m8", jpc, 32'hFFFF_FFF8);
    fetch(1'b0, 32'h0, ADDI);
    check("other_taken", {31'd0, taken}, 32'd0);

    // Gshare training at PC 0x100 with snapshot 0x05 lands on index 0x45
    upd(32'h100, 8'h05, 1'b1, 1'b0);
    upd(32'h100, 8'h05, 1'b1, 1'b0);
    fetch(1'b0, 32'h114, BR_P16);
    check("gs_idx45_taken", {31'd0, taken}, 32'd1);
    fetch(1'b0, 32'h100, BR_P16);
    check("gs_idx40_not", {31'd0, taken}, 32'd0);
    check("gs_stat_upd", su, 32'd2);
    check("gs_stat_mis", sm, 32'd0);

    // Speculative history: taken, not taken, JAL, taken -> 3'b101
    fetch(1'b1, 32'h114, BR_P16);
    check("ghr_p1_taken", {31'd0, taken}, 32'd1);
    tick(); pv = 1'b0;
    fetch(1'b1, 32'h100, BR_P16);
    check("ghr_p2_not", {31'd0, taken}, 32'd0);
    check("ghr_after_p1", {24'd0, snap}, 32'h01);
    tick(); pv = 1'b0;
    fetch(1'b1, 32'h100, JAL_P2K);
    check("ghr_after_p2", {24'd0, snap}, 32'h02);
    tick(); pv = 1'b0;
    fetch(1'b1, 32'h11C, BR_P16);
    check("ghr_after_jal", {24'd0, snap}, 32'h02);
    check("ghr_p3_taken", {31'd0, taken}, 32'd1);
    tick(); pv = 1'b0;
    fetch(1'b0, 32'h100, BR_P16);
    check("ghr_101", {24'd0, snap}, 32'h05);
    check("gs_live_ghr5_taken", {31'd0, taken}, 32'd1);

    // Repair beats a same-cycle speculative shift
    fetch(1'b1, 32'h100, BR_P16);
    upd(32'h200, 8'h0F, 1'b0, 1'b1);
    pv = 1'b0;
    #1;
    check("repair_ghr", {24'd0, snap}, 32'h1E);
    check("repair_stat_upd", su, 32'd3);
    check("repair_stat_mis", sm, 32'd1);

    // Mispredict without enable is ignored
    mis = 1'b1;
    tick();
    mis = 1'b0;
    check("mis_noen_ghr", {24'd0, snap}, 32'h1E);
    check("mis_noen_upd", su, 32'd3);
    check("mis_noen_mis", sm, 32'd1);

    // Same-cycle read/write of one entry sees the old counter
    fetch(1'b0, 32'h300, BR_P16);
    en = 1'b1; rpc = 32'h300; rsnap = 8'h1E; hit = 1'b1;
    #1;
    check("nobypass_old", {31'd0, taken}, 32'd0);
    tick();
    check("nobypass_written", {31'd0, taken}, 32'd1);
    tick();
    en = 1'b0;
    check("nobypass_stat_upd", su, 32'd5);

    // Bimodal instance: saturation at both ends
    #1;
    check("bm_init_not", {31'd0, b_taken}, 32'd0);
    b_upd(1'b1, 2);
    check("bm_tt_taken", {31'd0, b_taken}, 32'd1);
    b_upd(1'b1, 3);
    check("bm_sat_hi_taken", {31'd0, b_taken}, 32'd1);
    b_upd(1'b0, 1);
    check("bm_hi_held", {31'd0, b_taken}, 32'd1);
    b_upd(1'b0, 1);
    check("bm_dec_to1", {31'd0, b_taken}, 32'd0);
    b_upd(1'b0, 2);
    check("bm_floor", {31'd0, b_taken}, 32'd0);
    b_upd(1'b1, 1);
    check("bm_up_from0", {31'd0, b_taken}, 32'd0);
    b_upd(1'b1, 1);
    check("bm_lo_held", {31'd0, b_taken}, 32'd1);
    check("bm_stat_upd", b_su, 32'd11);
    check("bm_stat_mis", b_sm, 32'd0);

    // Asynchronous reset in the middle of a training stream
    en = 1'b1; rpc = 32'h100; rsnap = 8'h05; hit = 1'b1;
    tick();
    #20;
    rst_n = 1'b0;
    fetch(1'b0, 32'h114, BR_P16);
    check("arst_stat_upd", su, 32'd0);
    check("arst_stat_mis", sm, 32'd0);
    check("arst_snap", {24'd0, snap}, 32'd0);
    check("arst_trained_not", {31'd0, taken}, 32'd0);
    check("arst_bm_stat", b_su, 32'd0);
    en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    en = 1'b1; rpc = 32'h114; rsnap = 8'h00; hit = 1'b1;
    tick();
    en = 1'b0;
    #1;
    check("post_rst_stat_upd", su, 32'd1);
    check("post_rst_trained", {31'd0, taken}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised successor to the fetch-stage bimodal predictor. It holds a pattern history table (PHT) of saturating counters and a speculative global history register (GHR), with optional gshare indexing. Prediction is combinational and used by the fetcher in the same cycle. Training arrives from the ROB at commit, and history is repaired on mispredict. It sits between the instruction fetcher and the ROB in the IF stage.

## Interface
Parameters:
- `PHT_ENTRIES`, default 256: PHT depth. Must be a power of two; `IDX_W = $clog2(PHT_ENTRIES)`.
- `CNT_BITS`, default 2: counter width, 2..4.
- `HIST_LEN`, default 8: GHR length, 1..`IDX_W`.
- `USE_GSHARE`, default 1: index mode. 1 means `pc[IDX_W+1:2] ^ {0, ghr}`; 0 means bimodal `pc[IDX_W+1:2]` and the GHR is still maintained.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `predict_valid_from_fch`  in  1  the fetcher issues the instruction this cycle.
- `predict_pc_from_fch`  in  32  PC of the fetched instruction.
- `predict_inst_from_fch`  in  32  raw instruction word.
- `predicted_jump_sign_to_fch`  out  1  predicted taken.
- `jump_pc_to_fch`  out  32  sign-extended offset: J-immediate for JAL, B-immediate otherwise.
- `ghr_snapshot_to_fch`  out  `HIST_LEN`  GHR value used to form this prediction. It travels with the instruction down to the ROB.
- `enable_sign_from_rob`  in  1  a committed conditional branch updates this cycle.
- `pc_from_rob`  in  32  PC of the committed branch.
- `ghr_snapshot_from_rob`  in  `HIST_LEN`  snapshot carried with the branch.
- `hit_from_rob`  in  1  actual outcome; 1 means taken.
- `mispredict_from_rob`  in  1  prediction was wrong. Qualified by the enable.
- `stat_updates`  out  32  committed-branch count.
- `stat_mispredicts`  out  32  mispredict count.

## Operation
- Counters are unsigned `CNT_BITS`-wide values. The prediction is the counter MSB.
  - Reset value is weakly-not-taken, `2^(CNT_BITS-1)-1`. With `CNT_BITS=2` this is `2'b01`.
- Predict side (combinational):
  - Opcode JAL → taken.
  - Opcode BRANCH → `PHT[idx_pred][CNT_BITS-1]`.
  - Any other opcode → not taken.
  - `ghr_snapshot_to_fch` = current GHR, before any shift.
- Speculative history: on `predict_valid_from_fch` with opcode BRANCH, `GHR <= {GHR[HIST_LEN-2:0], predicted_taken}`. With `HIST_LEN=1`, `GHR <= predicted_taken`. JAL and other instructions do not shift the GHR.
- Training on `enable_sign_from_rob`:
  - `idx_upd` is computed from `pc_from_rob` and `ghr_snapshot_from_rob`, never from the live GHR.
  - Taken increments the counter, saturating at `2^CNT_BITS-1`. Not taken decrements it, saturating at 0.
  - Arithmetic is done at `CNT_BITS+1` width, or by explicit compare; no wrap-around is allowed.
- Repair: enable && mispredict sets `GHR <= {ghr_snapshot_from_rob[HIST_LEN-2:0], hit_from_rob}`. This has priority over a same-cycle speculative shift, so the fetch-side shift is discarded.
- Statistics:
  - `stat_updates` increments on every enable.
  - `stat_mispredicts` increments on enable && mispredict.
  - Both saturate at `32'hFFFF_FFFF`.
- `mispredict_from_rob` without `enable_sign_from_rob` is ignored.

## Timing
- Prediction outputs have zero latency and are combinational from the fetch inputs plus registered state.
- PHT write and GHR update take effect on the rising edge; they are visible to predictions one cycle later.
- Same-cycle read and write of one PHT entry: the prediction sees the old value; there is no bypass.
- Reset (`rst_n` low, any time, including mid-stream) asynchronously:
  - sets all counters to weakly-not-taken;
  - sets GHR to 0;
  - sets both statistics to 0.
- Outputs while in reset: taken = 0 for branches and 1 for JAL; snapshot = 0.
- The first edge after `rst_n` rises behaves normally.
- No handshake: the ROB delivers at most one update per cycle, and the fetcher at most one prediction per cycle.

## Structure
- Shared defines header holds:
  - `OPCODE_RANGE`, `OPCODE_JAL`, `OPCODE_BR`, `ADDR_TYPE`, `INST_TYPE`;
  - the new counter-state encodings as functions of `CNT_BITS`: weak-not-taken and saturation limits.
- One natural sub-module, `sat_counter_update`: combinational next-value of an `N`-bit saturating counter given the direction.
- The PHT is a flop array because it needs asynchronous reset of every entry; it must not be inferred as BRAM.

## Test plan
- Reset, then fetch BRANCH at PC `0x100` → not taken, `jump_pc` = B-immediate, snapshot `8'h00`. Fetch JAL → taken, `jump_pc` = J-immediate.
- Bimodal mode (`USE_GSHARE=0`), `CNT_BITS=2`: two taken updates at PC `0x100` → the next prediction is taken. Three more taken updates → the counter stays at 3. Four not-taken updates → the counter reaches 0 and stays there.
- GHR shift: predict three BRANCHes predicted taken/not/taken → GHR = `8'b101`. JAL in between leaves the GHR unchanged.
- Gshare index: update PC `0x100` with snapshot `8'h05` taken ×2 → only index `0x40^0x05 = 0x45` predicts taken; a prediction with GHR 0 at the same PC is still not taken.
- Mispredict repair: while fetch shifts in the same cycle, enable + mispredict with snapshot `8'h0F` and hit = 0 → next GHR = `8'h1E`. `stat_mispredicts` = 1 and `stat_updates` = 1.
- Assert `rst_n` asynchronously mid-training (between clock edges) → counters, GHR and statistics clear immediately; a BRANCH at a previously trained PC predicts not taken.
